// File: rtl/ramen_timer_ctrl.sv
// Ramen countdown timer: IDLE/RUN/PAUSE/DONE control, BCD mm:ss countdown and 4-digit scan mux.
// Define RAMEN_TIMER_BLINK_EN to blank the display during the second half of each second in PAUSE/DONE.
module ramen_timer_ctrl #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int SCAN_DIV    = 50_000,
    parameter int DEFAULT_MIN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_up,
    input  logic        btn_clear,
    output logic        sec_tick,
    output logic [15:0] time_bcd,
    output logic [3:0]  seg_sel,
    output logic [3:0]  seg_digit,
    output logic [1:0]  state,
    output logic        alarm
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [15:0]       PRESET    = {4'(DEFAULT_MIN / 10), 4'(DEFAULT_MIN % 10), 8'h00};

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         time_q, time_d;
    logic [TICK_W-1:0]   presc_q, presc_d, presc_inc;
    logic                tick_q, tick_d;
    logic                presc_wrap;
    logic [SCAN_W-1:0]   scan_q;
    logic [1:0]          sidx_q;
    logic [15:0]         time_dec;
    logic [3:0]          sel_onehot;

    // One-second BCD decrement with borrow; only applied to a nonzero time.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    // Add one minute, minute field saturating at 99.
    function automatic logic [15:0] bcd_add_min(input logic [15:0] t);
        logic [3:0] m1, m0;
        {m1, m0} = t[15:8];
        if ({m1, m0} == 8'h99) begin
            return t;
        end
        if (m0 == 4'd9) begin
            m0 = 4'd0;
            m1 = m1 + 4'd1;
        end else begin
            m0 = m0 + 4'd1;
        end
        return {m1, m0, t[7:0]};
    endfunction

    assign presc_wrap = (presc_q == TICK_LAST);
    assign presc_inc  = presc_wrap ? '0 : presc_q + TICK_W'(1);
    assign time_dec   = bcd_dec(time_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            time_q  <= PRESET;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (btn_clear) begin
            state_d = S_IDLE;
            time_d  = PRESET;
            presc_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (btn_start) begin
                        if (time_q != 16'h0000) begin
                            state_d = S_RUN;
                            presc_d = '0;
                        end
                    end else if (btn_up) begin
                        time_d = bcd_add_min(time_q);
                    end
                end
                S_RUN: begin
                    presc_d = presc_inc;
                    if (btn_start) begin
                        state_d = S_PAUSE;
                    end
                    // A tick in the pausing cycle still counts; expiry overrides the pause.
                    if (presc_wrap) begin
                        tick_d = 1'b1;
                        time_d = time_dec;
                        if (time_dec == 16'h0000) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (btn_start) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    presc_d = presc_inc;
                    if (btn_start) begin
                        state_d = S_IDLE;
                        time_d  = PRESET;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q <= '0;
            sidx_q <= 2'd0;
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            sidx_q <= sidx_q + 2'd1;
        end else begin
            scan_q <= scan_q + SCAN_W'(1);
        end
    end

    always_comb begin
        sel_onehot = 4'b0001 << sidx_q;
        alarm      = (state_q == S_DONE);
`ifdef RAMEN_TIMER_BLINK_EN
        if ((state_q == S_PAUSE || state_q == S_DONE) && presc_q >= TICK_W'(TICK_DIV / 2)) begin
            seg_sel = 4'b0000;
        end else begin
            seg_sel = sel_onehot;
        end
`else
        seg_sel = sel_onehot;
`endif
        case (sidx_q)
            2'd0:    seg_digit = time_q[3:0];
            2'd1:    seg_digit = time_q[7:4];
            2'd2:    seg_digit = time_q[11:8];
            default: seg_digit = time_q[15:12];
        endcase
    end

    assign sec_tick = tick_q;
    assign time_bcd = time_q;
    assign state    = state_q;

endmodule

// File: tb/tb_ramen_timer_ctrl.sv
// Bench for ramen_timer_ctrl: seconds-based reference model checked every cycle plus directed literal checks.
module tb_ramen_timer_ctrl;
    localparam int TICK_DIV    = 4;
    localparam int SCAN_DIV    = 2;
    localparam int DEFAULT_MIN = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start, btn_up, btn_clear;
    logic        sec_tick;
    logic [15:0] time_bcd;
    logic [3:0]  seg_sel, seg_digit;
    logic [1:0]  state;
    logic        alarm;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    ramen_timer_ctrl #(
        .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .DEFAULT_MIN(DEFAULT_MIN)
    ) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_up(btn_up), .btn_clear(btn_clear),
        .sec_tick(sec_tick), .time_bcd(time_bcd), .seg_sel(seg_sel), .seg_digit(seg_digit),
        .state(state), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining time as plain seconds, scan position from a cycle count.
    int m_secs, m_state, m_presc, m_cyc;
    bit m_tick, m_wrap;

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_secs = DEFAULT_MIN * 60; m_state = 0; m_presc = 0; m_cyc = 0; m_tick = 0;
        end else begin
            m_tick = 0;
            m_cyc++;
            if (btn_clear) begin
                m_state = 0; m_secs = DEFAULT_MIN * 60; m_presc = 0;
            end else begin
                case (m_state)
                    0: if (btn_start) begin
                           if (m_secs > 0) begin m_state = 1; m_presc = 0; end
                       end else if (btn_up && (m_secs / 60) < 99) m_secs += 60;
                    1: begin
                           m_wrap = (m_presc == TICK_DIV - 1);
                           m_presc = (m_presc + 1) % TICK_DIV;
                           if (btn_start) m_state = 2;
                           if (m_wrap) begin
                               m_tick = 1; m_secs--;
                               if (m_secs == 0) m_state = 3;
                           end
                       end
                    2: if (btn_start) m_state = 1;
                    default: begin
                           m_presc = (m_presc + 1) % TICK_DIV;
                           if (btn_start) begin m_state = 0; m_secs = DEFAULT_MIN * 60; end
                       end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int idx;
            logic [15:0] bcd;
            logic [3:0] esel;
            idx  = (m_cyc / SCAN_DIV) % 4;
            bcd  = to_bcd(m_secs);
            esel = 4'(1 << idx);
`ifdef RAMEN_TIMER_BLINK_EN
            if (m_state >= 2 && m_presc >= TICK_DIV / 2) esel = 4'b0000;
`endif
            check("model time_bcd", time_bcd, bcd);
            check("model state", 16'(state), 16'(m_state));
            check("model sec_tick", 16'(sec_tick), 16'(m_tick));
            check("model alarm", 16'(alarm), 16'(m_state == 3));
            check("model seg_sel", 16'(seg_sel), 16'(esel));
            check("model seg_digit", 16'(seg_digit), 16'((bcd >> (4 * idx)) & 16'hF));
        end
    end

    task automatic pulse(input int which);
        case (which)
            0: btn_start = 1'b1;
            1: btn_up    = 1'b1;
            2: btn_clear = 1'b1;
            default: begin btn_start = 1'b1; btn_clear = 1'b1; end
        endcase
        @(negedge clk);
        btn_start = 1'b0; btn_up = 1'b0; btn_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_sel [4];
        logic [3:0] exp_dig [4];
        exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_dig = '{4'd0, 4'd0, 4'd1, 4'd0};
        rst = 1'b0; btn_start = 1'b0; btn_up = 1'b0; btn_clear = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset time_bcd", time_bcd, 16'h0100);
        check("reset state", 16'(state), 16'h0000);
        check("reset seg_sel", 16'(seg_sel), 16'h0001);
        check("reset sec_tick", 16'(sec_tick), 16'h0000);
        check("reset alarm", 16'(alarm), 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Idle scan: 2 cycles per digit
        for (int k = 0; k < 16; k++) begin
            check("idle seg_sel", 16'(seg_sel), 16'(exp_sel[(k / 2) % 4]));
            check("idle seg_digit", 16'(seg_digit), 16'(exp_dig[(k / 2) % 4]));
            @(negedge clk);
        end

        pulse(1); pulse(1);
        check("up x2 time", time_bcd, 16'h0300);
        check("up x2 state", 16'(state), 16'h0000);
        pulse(2);
        check("clear reload", time_bcd, 16'h0100);

        // First second and minute borrow
        pulse(0);
        repeat (3) @(negedge clk);
        check("no early tick", 16'(sec_tick), 16'h0000);
        @(negedge clk);
        check("first tick", 16'(sec_tick), 16'h0001);
        check("first dec", time_bcd, 16'h0059);
        repeat (32) @(negedge clk);
        check("8 ticks later", time_bcd, 16'h0051);

        // Pause at prescaler 2, hold, resume
        repeat (2) @(negedge clk);
        pulse(0);
        check("pause state", 16'(state), 16'h0002);
        repeat (20) @(negedge clk);
        check("pause hold time", time_bcd, 16'h0051);
        check("pause hold state", 16'(state), 16'h0002);
        pulse(0);
        check("resume state", 16'(state), 16'h0001);
        check("resume no tick yet", 16'(sec_tick), 16'h0000);
        @(negedge clk);
        check("resume tick", 16'(sec_tick), 16'h0001);
        check("resume dec", time_bcd, 16'h0050);

        // Clear + start on a would-be tick cycle
        repeat (3) @(negedge clk);
        pulse(3);
        check("clear+start state", 16'(state), 16'h0000);
        check("clear+start time", time_bcd, 16'h0100);
        check("clear+start no tick", 16'(sec_tick), 16'h0000);

        // Minute-tens borrow 10:00 -> 09:59
        repeat (9) pulse(1);
        check("up to 10:00", time_bcd, 16'h1000);
        pulse(0);
        repeat (4) @(negedge clk);
        check("tens borrow", time_bcd, 16'h0959);
        pulse(2);

        // Minute saturation at 99
        repeat (98) pulse(1);
        check("up to 99", time_bcd, 16'h9900);
        pulse(1);
        check("saturate 99", time_bcd, 16'h9900);
        pulse(2);

        // Expiry from 01:00
        pulse(0);
        repeat (239) @(negedge clk);
        check("pre-expiry time", time_bcd, 16'h0001);
        check("pre-expiry alarm", 16'(alarm), 16'h0000);
        @(negedge clk);
        check("expiry time", time_bcd, 16'h0000);
        check("expiry state", 16'(state), 16'h0003);
        check("expiry alarm", 16'(alarm), 16'h0001);
        repeat (2) @(negedge clk);
`ifdef RAMEN_TIMER_BLINK_EN
        check("done blink blank", 16'(seg_sel), 16'h0000);
`endif
        pulse(1);
        check("up ignored in done", time_bcd, 16'h0000);
        pulse(0);
        check("ack state", 16'(state), 16'h0000);
        check("ack time", time_bcd, 16'h0100);
        check("ack alarm", 16'(alarm), 16'h0000);

        // Asynchronous reset mid-RUN
        pulse(0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst state", 16'(state), 16'h0000);
        check("async rst time", time_bcd, 16'h0100);
        check("async rst seg_sel", 16'(seg_sel), 16'h0001);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post rst idle", 16'(state), 16'h0000);
        pulse(0);
        check("post rst start", 16'(state), 16'h0001);
        repeat (2) @(negedge clk);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
